// File: rtl/onehot_pkg.sv
// onehot_pkg: shared types for the one-hot stepper.
//   cmd_e   - command encoding on the cmd input
//   state_e - index state machine states (no line active / one line active)
package onehot_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_UP    = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational binary-to-one-hot decoder.
// Ports:
//   en  in  1      enable; all outputs zero when low
//   idx in  IN_W   binary index
//   y   out OUT_W  one-hot decode; all zero when idx >= OUT_W
module onehot_dec #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic             en,
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] y
);

  // Indices at or above OUT_W match no line, so they decode to zero.
  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (en && (idx == IN_W'(i))) y[i] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_stepper.sv
// onehot_stepper: registered one-hot select with an index state machine
// (LOAD / UP / DOWN / CLEAR) and a one-entry valid/ready output stage.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    command handshake
//   cmd, idx             command and LOAD index
//   out_valid/out_ready  result handshake
//   y, idx_q             one-hot select and current index (0 when EMPTY)
//   wrapped, err         per-result flags
//   state_dbg            current state machine state
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = !rst && (!out_valid || out_ready) and never looks at in_valid.
// A result stays stable while out_valid && !out_ready.
module onehot_stepper
  import onehot_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       cmd,
  input  logic [IN_W-1:0]  idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic [IN_W-1:0]  idx_q,
  output logic             wrapped,
  output logic             err,
  output state_e           state_dbg
);

  // One extra bit so OUT_W itself is representable when OUT_W == 2**IN_W.
  localparam int XW = IN_W + 1;
  localparam logic [XW-1:0] LIMIT = XW'(OUT_W);
  localparam logic [XW-1:0] LAST  = XW'(OUT_W - 1);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    cur_q, cur_d;
  logic [OUT_W-1:0]   y_q, dec_y;
  logic               out_valid_q, wrapped_q, err_q;
  logic               wrapped_d, err_d;
  logic               accept;
  logic [XW-1:0]      cur_x, ld_x, nxt_x;
  logic               unused_nxt_msb;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign cur_x = {1'b0, cur_q};
  assign ld_x  = {1'b0, idx};

  always_comb begin
    state_d   = state_q;
    nxt_x     = cur_x;
    wrapped_d = 1'b0;
    err_d     = 1'b0;
    case (cmd_e'(cmd))
      CMD_LOAD: begin
        if (ld_x < LIMIT) begin
          state_d = ST_ACTIVE;
          nxt_x   = ld_x;
        end else begin
          state_d = ST_EMPTY;
          nxt_x   = '0;
          err_d   = 1'b1;
        end
      end
      CMD_UP: begin
        if (state_q == ST_EMPTY) begin
          state_d = ST_ACTIVE;
          nxt_x   = '0;
        end else if (cur_x == LAST) begin
          // Saturating mode keeps the index but still flags the end hit.
          wrapped_d = 1'b1;
          if (WRAP) nxt_x = '0;
        end else begin
          nxt_x = cur_x + XW'(1);
        end
      end
      CMD_DOWN: begin
        if (state_q == ST_EMPTY) begin
          state_d = ST_ACTIVE;
          nxt_x   = LAST;
        end else if (cur_x == '0) begin
          wrapped_d = 1'b1;
          if (WRAP) nxt_x = LAST;
        end else begin
          nxt_x = cur_x - XW'(1);
        end
      end
      default: begin
        state_d = ST_EMPTY;
        nxt_x   = '0;
      end
    endcase
  end

  // nxt_x never reaches OUT_W, so its top bit is always zero.
  assign cur_d          = nxt_x[IN_W-1:0];
  assign unused_nxt_msb = nxt_x[IN_W];

  onehot_dec #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .en  (state_d == ST_ACTIVE),
    .idx (cur_d),
    .y   (dec_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      cur_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      wrapped_q   <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      // Covers accept-and-drain too: the new result replaces the old one.
      state_q     <= state_d;
      cur_q       <= cur_d;
      y_q         <= dec_y;
      wrapped_q   <= wrapped_d;
      err_q       <= err_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      // Drain only: y/idx_q keep the last state value.
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign idx_q     = cur_q;
  assign wrapped   = wrapped_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_onehot_stepper.sv
// Bench for onehot_stepper: three instances (WRAP=1/8 lines, WRAP=0/8 lines,
// WRAP=1/6 lines) share one stimulus stream and are checked against an
// integer-index reference model.
module tb_onehot_stepper;
  import onehot_pkg::*;

  localparam int C_LOAD  = 0;
  localparam int C_UP    = 1;
  localparam int C_DOWN  = 2;
  localparam int C_CLEAR = 3;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [2:0] idx = 3'd0;

  logic [7:0] y_a  [3];
  logic [5:0] y6;
  logic [2:0] iq_a [3];
  logic       ir_a [3];
  logic       ov_a [3];
  logic       wr_a [3];
  logic       er_a [3];
  state_e     st_a [3];

  assign y_a[2] = {2'b00, y6};

  onehot_stepper #(.IN_W(3), .OUT_W(8), .WRAP(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a[0]), .cmd(cmd), .idx(idx),
    .out_valid(ov_a[0]), .out_ready(out_ready), .y(y_a[0]), .idx_q(iq_a[0]),
    .wrapped(wr_a[0]), .err(er_a[0]), .state_dbg(st_a[0])
  );

  onehot_stepper #(.IN_W(3), .OUT_W(8), .WRAP(1'b0)) u_w0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a[1]), .cmd(cmd), .idx(idx),
    .out_valid(ov_a[1]), .out_ready(out_ready), .y(y_a[1]), .idx_q(iq_a[1]),
    .wrapped(wr_a[1]), .err(er_a[1]), .state_dbg(st_a[1])
  );

  onehot_stepper #(.IN_W(3), .OUT_W(6), .WRAP(1'b1)) u_o6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a[2]), .cmd(cmd), .idx(idx),
    .out_valid(ov_a[2]), .out_ready(out_ready), .y(y6), .idx_q(iq_a[2]),
    .wrapped(wr_a[2]), .err(er_a[2]), .state_dbg(st_a[2])
  );

  // ---------------- reference model ----------------
  int ow [3] = '{8, 8, 6};
  bit wp [3] = '{1'b1, 1'b0, 1'b1};
  int m_cur [3];          // -1 = no line active
  bit m_wr  [3];
  bit m_er  [3];
  bit m_valid;
  bit exp_ready;
  bit obs_ready [3];

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] exp_y(int k);
    if (m_cur[k] < 0) return 8'h00;
    return 8'(1 << m_cur[k]);
  endfunction

  function automatic logic [2:0] exp_idx(int k);
    if (m_cur[k] < 0) return 3'd0;
    return 3'(m_cur[k]);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cur[k] = -1;
      m_wr[k]  = 1'b0;
      m_er[k]  = 1'b0;
    end
    m_valid = 1'b0;
  endfunction

  function automatic void model_apply(int k, int c, int ix);
    int n;
    n = ow[k];
    m_wr[k] = 1'b0;
    m_er[k] = 1'b0;
    case (c)
      C_LOAD: begin
        if (ix < n) m_cur[k] = ix;
        else begin
          m_cur[k] = -1;
          m_er[k]  = 1'b1;
        end
      end
      C_UP: begin
        if (m_cur[k] < 0) m_cur[k] = 0;
        else if (m_cur[k] == n - 1) begin
          m_wr[k] = 1'b1;
          if (wp[k]) m_cur[k] = 0;
        end else m_cur[k] = m_cur[k] + 1;
      end
      C_DOWN: begin
        if (m_cur[k] < 0) m_cur[k] = n - 1;
        else if (m_cur[k] == 0) begin
          m_wr[k] = 1'b1;
          if (wp[k]) m_cur[k] = n - 1;
        end else m_cur[k] = m_cur[k] - 1;
      end
      default: m_cur[k] = -1;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One clock: drive inputs, capture in_ready before the edge, advance the
  // model across the edge, return 1 time unit after the edge.
  task automatic drive_cycle(input bit v, input int c, input int ix, input bit ordy, input bit r);
    in_valid  = v;
    cmd       = 2'(c);
    idx       = 3'(ix);
    out_ready = ordy;
    rst       = r;
    #1;
    exp_ready = !r && (!m_valid || ordy);
    for (int k = 0; k < 3; k++) obs_ready[k] = ir_a[k];
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (v && exp_ready) begin
      for (int k = 0; k < 3; k++) model_apply(k, c, ix);
      m_valid = 1'b1;
    end else if (ordy) m_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_cycle(1'b1, C_UP, 0, 1'b1, 1'b1);
    drive_cycle(1'b1, C_UP, 0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_ready[k] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d] got=%b exp=0", k, obs_ready[k]); end
      checks++;
      if (ov_a[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", k, ov_a[k]); end
      checks++;
      if (y_a[k] !== 8'h00 || iq_a[k] !== 3'd0) begin
        errors++; $display("FAIL reset_y_idx[%0d] got y=%h idx=%0d exp y=00 idx=0", k, y_a[k], iq_a[k]);
      end
      checks++;
      if (wr_a[k] !== 1'b0 || er_a[k] !== 1'b0 || st_a[k] !== ST_EMPTY) begin
        errors++; $display("FAIL reset_flags[%0d] got wr=%b err=%b st=%0d exp 0 0 0", k, wr_a[k], er_a[k], st_a[k]);
      end
    end
  endtask

  task automatic test_load();
    drive_cycle(1'b1, C_LOAD, 5, 1'b1, 1'b0);
    checks++;
    if (y_a[0] !== 8'b0010_0000 || iq_a[0] !== 3'd5) begin
      errors++; $display("FAIL load5 got y=%b idx=%0d exp y=00100000 idx=5", y_a[0], iq_a[0]);
    end
    checks++;
    if (ov_a[0] !== 1'b1 || er_a[0] !== 1'b0 || wr_a[0] !== 1'b0) begin
      errors++; $display("FAIL load5_flags got ov=%b err=%b wr=%b exp 1 0 0", ov_a[0], er_a[0], wr_a[0]);
    end
  endtask

  task automatic test_out_of_range();
    drive_cycle(1'b1, C_LOAD, 7, 1'b1, 1'b0);
    checks++;
    if (y_a[2] !== 8'h00 || er_a[2] !== 1'b1 || st_a[2] !== ST_EMPTY || iq_a[2] !== 3'd0) begin
      errors++; $display("FAIL oob_load got y=%h err=%b st=%0d idx=%0d exp y=00 err=1 st=0 idx=0",
                         y_a[2], er_a[2], st_a[2], iq_a[2]);
    end
    checks++;
    if (y_a[0] !== 8'h80 || er_a[0] !== 1'b0) begin
      errors++; $display("FAIL inrange_load7 got y=%h err=%b exp y=80 err=0", y_a[0], er_a[0]);
    end
    drive_cycle(1'b1, C_UP, 0, 1'b1, 1'b0);
    checks++;
    if (y_a[2] !== 8'h01 || er_a[2] !== 1'b0 || wr_a[2] !== 1'b0) begin
      errors++; $display("FAIL oob_then_up got y=%h err=%b wr=%b exp y=01 err=0 wr=0", y_a[2], er_a[2], wr_a[2]);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, C_LOAD, 7, 1'b1, 1'b0);
    drive_cycle(1'b1, C_UP, 0, 1'b1, 1'b0);
    checks++;
    if (y_a[0] !== 8'h01 || wr_a[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_up got y=%h wr=%b exp y=01 wr=1", y_a[0], wr_a[0]);
    end
    checks++;
    if (y_a[1] !== 8'h80 || iq_a[1] !== 3'd7 || wr_a[1] !== 1'b1) begin
      errors++; $display("FAIL sat_up got y=%h idx=%0d wr=%b exp y=80 idx=7 wr=1", y_a[1], iq_a[1], wr_a[1]);
    end
    drive_cycle(1'b1, C_DOWN, 0, 1'b1, 1'b0);
    checks++;
    if (y_a[0] !== 8'h80 || wr_a[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_down got y=%h wr=%b exp y=80 wr=1", y_a[0], wr_a[0]);
    end
    checks++;
    if (y_a[1] !== 8'h40 || wr_a[1] !== 1'b0) begin
      errors++; $display("FAIL sat_inner_down got y=%h wr=%b exp y=40 wr=0", y_a[1], wr_a[1]);
    end
    drive_cycle(1'b1, C_LOAD, 7, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      drive_cycle(1'b1, C_UP, 0, 1'b1, 1'b0);
      checks++;
      if (y_a[1] !== 8'h80 || iq_a[1] !== 3'd7 || wr_a[1] !== 1'b1 || ov_a[1] !== 1'b1) begin
        errors++; $display("FAIL sat_repeat%0d got y=%h idx=%0d wr=%b ov=%b exp y=80 idx=7 wr=1 ov=1",
                           n, y_a[1], iq_a[1], wr_a[1], ov_a[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, C_LOAD, 2, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      drive_cycle(1'b1, C_UP, 0, 1'b0, 1'b0);
      checks++;
      if (obs_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got=%b exp=0", n, obs_ready[0]); end
      checks++;
      if (y_a[0] !== 8'h04 || iq_a[0] !== 3'd2 || ov_a[0] !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got y=%h idx=%0d ov=%b exp y=04 idx=2 ov=1", n, y_a[0], iq_a[0], ov_a[0]);
      end
    end
    for (int n = 0; n < 4; n++) begin
      drive_cycle(1'b1, C_UP, 0, 1'b1, 1'b0);
      checks++;
      if (obs_ready[0] !== 1'b1 || iq_a[0] !== 3'(3 + n) || ov_a[0] !== 1'b1) begin
        errors++; $display("FAIL b2b_step%0d got rdy=%b idx=%0d ov=%b exp rdy=1 idx=%0d ov=1",
                           n, obs_ready[0], iq_a[0], ov_a[0], 3 + n);
      end
    end
    drive_cycle(1'b0, C_UP, 0, 1'b1, 1'b0);
    checks++;
    if (ov_a[0] !== 1'b0 || iq_a[0] !== 3'd6 || y_a[0] !== 8'h40) begin
      errors++; $display("FAIL drain got ov=%b idx=%0d y=%h exp ov=0 idx=6 y=40", ov_a[0], iq_a[0], y_a[0]);
    end
  endtask

  task automatic test_reset_stall();
    drive_cycle(1'b1, C_LOAD, 3, 1'b1, 1'b0);
    drive_cycle(1'b0, C_LOAD, 0, 1'b0, 1'b0);
    drive_cycle(1'b1, C_UP, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov_a[k] !== 1'b0 || y_a[k] !== 8'h00 || iq_a[k] !== 3'd0) begin
        errors++; $display("FAIL rst_stall[%0d] got ov=%b y=%h idx=%0d exp 0 00 0", k, ov_a[k], y_a[k], iq_a[k]);
      end
    end
    drive_cycle(1'b1, C_DOWN, 0, 1'b1, 1'b0);
    checks++;
    if (y_a[0] !== 8'h80 || y_a[2] !== 8'h20) begin
      errors++; $display("FAIL rst_then_down got y8=%h y6=%h exp y8=80 y6=20", y_a[0], y_a[2]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_ready[k] !== exp_ready || ov_a[k] !== m_valid) begin
          errors++; $display("FAIL rnd_hs[%0d] cyc=%0d got rdy=%b ov=%b exp rdy=%b ov=%b",
                             k, n, obs_ready[k], ov_a[k], exp_ready, m_valid);
        end
        checks++;
        if (y_a[k] !== exp_y(k) || iq_a[k] !== exp_idx(k)) begin
          errors++; $display("FAIL rnd_sel[%0d] cyc=%0d got y=%h idx=%0d exp y=%h idx=%0d",
                             k, n, y_a[k], iq_a[k], exp_y(k), exp_idx(k));
        end
        checks++;
        if (wr_a[k] !== m_wr[k] || er_a[k] !== m_er[k]) begin
          errors++; $display("FAIL rnd_flags[%0d] cyc=%0d got wr=%b err=%b exp wr=%b err=%b",
                             k, n, wr_a[k], er_a[k], m_wr[k], m_er[k]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_load();
    test_out_of_range();
    test_wrap();
    test_backpressure();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
